spectrum_bar_builder: RTL and testbench

- Sits between the 64-point FFT and the VGA renderer, replacing the combinational FFT-to-VGA rescale path.
- On each FFT completion it snapshots the complex bins and computes one L1 magnitude per clock.
- It scales and saturates each magnitude to a bar height, then applies per-frame peak-hold with linear decay.
- Results go to a work buffer and are copied to the displayed bar array only on a vsync falling edge, giving tear-free output.

---
 rtl/spectrum_pkg.sv | 22 ++
 rtl/spectrum_bar_builder_bin_to_height.sv | 33 +++
 rtl/spectrum_bar_builder.sv | 100 ++++++++++
 tb/tb_spectrum_bar_builder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_pkg.sv
// Shared sizes, types and FSM encoding for the spectrum bar builder and its
// per-bin height calculator.
package spectrum_pkg;

   localparam int POINTS  = 64;
   localparam int HALF_W  = 18;
   localparam int BAR_W   = 9;
   localparam int SHIFT   = 6;
   localparam int BAR_MAX = 480;
   localparam int DECAY   = 2;
   localparam int IDX_W   = $clog2(POINTS);

   typedef logic signed [HALF_W-1:0] bin_t;
   typedef logic [BAR_W-1:0]         bar_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/spectrum_bar_builder_bin_to_height.sv
// One FFT bin to one bar height: L1 magnitude, shift, saturate, and
// peak-hold against the decayed currently displayed bar.
module bin_to_height
   import spectrum_pkg::*;
(
   input  bin_t re,
   input  bin_t im,
   input  bar_t prev_bar,
   output bar_t next_bar
);

   localparam int SH_W = HALF_W + 1 - SHIFT;

   logic [HALF_W-1:0] abs_re;
   logic [HALF_W-1:0] abs_im;
   logic [HALF_W:0]   mag;
   logic [SH_W-1:0]   shifted;
   bar_t              new_bar;
   bar_t              decayed;

   always_comb begin
      // Two's-complement negate kept at HALF_W bits, so the most negative
      // input maps to exactly 2^(HALF_W-1) as an unsigned value.
      abs_re   = re[HALF_W-1] ? (~re + HALF_W'(1)) : re;
      abs_im   = im[HALF_W-1] ? (~im + HALF_W'(1)) : im;
      mag      = {1'b0, abs_re} + {1'b0, abs_im};
      shifted  = mag[HALF_W:SHIFT];
      new_bar  = (shifted > SH_W'(BAR_MAX)) ? bar_t'(BAR_MAX) : shifted[BAR_W-1:0];
      decayed  = (prev_bar > bar_t'(DECAY)) ? (prev_bar - bar_t'(DECAY)) : '0;
      next_bar = (new_bar > decayed) ? new_bar : decayed;
   end

endmodule

// File: rtl/spectrum_bar_builder.sv
// Snapshots an FFT frame, turns one bin per clock into a held bar height,
// and publishes the whole bar set only on a vsync falling edge.
module spectrum_bar_builder
   import spectrum_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fft_done,
   input  logic [2*HALF_W-1:0]   fft_out [POINTS],
   input  logic                  vsync,
   output logic [BAR_W-1:0]      bars [POINTS],
   output logic                  busy,
   output logic                  overrun
);

   state_e              state_q;
   logic [IDX_W-1:0]    idx_q;
   logic [2*HALF_W-1:0] snap_q [POINTS];
   bar_t                work_q [POINTS];
   bar_t                bars_q [POINTS];
   logic                busy_q;
   logic                overrun_q;
   logic                fft_done_q;
   logic                vsync_q;

   logic                rise;
   logic                fall;
   bin_t                cur_re;
   bin_t                cur_im;
   bar_t                bar_d;

   assign rise   = fft_done & ~fft_done_q;
   assign fall   = vsync_q & ~vsync;
   assign cur_re = snap_q[idx_q][2*HALF_W-1:HALF_W];
   assign cur_im = snap_q[idx_q][HALF_W-1:0];

   bin_to_height u_bin_to_height (
      .re       (cur_re),
      .im       (cur_im),
      .prev_bar (bars_q[idx_q]),
      .next_bar (bar_d)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
         fft_done_q <= 1'b0;
         vsync_q    <= 1'b1;
         for (int i = 0; i < POINTS; i++) begin
            snap_q[i] <= '0;
            work_q[i] <= '0;
            bars_q[i] <= '0;
         end
      end else begin
         fft_done_q <= fft_done;
         vsync_q    <= vsync;
         // Only IDLE accepts a new frame; a rise anywhere else is a drop.
         overrun_q  <= rise && (state_q != IDLE);
         case (state_q)
            IDLE: begin
               if (rise) begin
                  for (int i = 0; i < POINTS; i++) snap_q[i] <= fft_out[i];
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= CALC;
               end
            end
            CALC: begin
               work_q[idx_q] <= bar_d;
               if (idx_q == IDX_W'(POINTS - 1)) begin
                  busy_q  <= 1'b0;
                  state_q <= HOLD;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            HOLD: begin
               if (fall) begin
                  for (int i = 0; i < POINTS; i++) bars_q[i] <= work_q[i];
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < POINTS; gi++) begin : g_bars
         assign bars[gi] = bars_q[gi];
      end
   endgenerate

   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_spectrum_bar_builder.sv
// Directed bench for spectrum_bar_builder with hand-computed bar heights.
module tb_spectrum_bar_builder;
   import spectrum_pkg::*;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                fft_done = 1'b0;
   logic [2*HALF_W-1:0] fft_out [POINTS];
   logic                vsync = 1'b1;
   logic [BAR_W-1:0]    bars [POINTS];
   logic                busy;
   logic                overrun;

   int n_cmp = 0;
   int n_bad = 0;
   int ovr_cnt = 0;
   int cyc;
   int exp_bars [POINTS];

   spectrum_bar_builder dut (
      .clock    (clock),
      .reset    (reset),
      .fft_done (fft_done),
      .fft_out  (fft_out),
      .vsync    (vsync),
      .bars     (bars),
      .busy     (busy),
      .overrun  (overrun)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (overrun === 1'b1) ovr_cnt++;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input int observed, input int expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic check_bars(input string tag);
      int bad = 0;
      int first = -1;
      for (int i = 0; i < POINTS; i++) begin
         if (int'(bars[i]) !== exp_bars[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      n_cmp++;
      assert (bad == 0) else begin
         n_bad++;
         $error("FAIL %s bins_wrong=%0d first_bin=%0d observed=%0d expected=%0d",
                tag, bad, first, bars[first], exp_bars[first]);
      end
   endtask

   task automatic clear_bins();
      for (int i = 0; i < POINTS; i++) fft_out[i] = '0;
   endtask

   task automatic set_bin(input int i, input int re, input int im);
      bin_t r;
      bin_t m;
      r = bin_t'(re);
      m = bin_t'(im);
      fft_out[i] = {r, m};
   endtask

   task automatic start_frame();
      fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
   endtask

   task automatic finish_frame(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         tick();
      end
      if (n >= 200) check("busy_timeout", n, 0);
   endtask

   task automatic vsync_fall();
      vsync = 1'b0;
      tick();
      vsync = 1'b1;
      tick();
   endtask

   initial begin
      int n;
      clear_bins();
      for (int i = 0; i < POINTS; i++) exp_bars[i] = 0;

      // 1: reset state, all-zero frame
      tick(); tick();
      reset = 1'b0;
      tick();
      check("reset_busy", busy, 0);
      check("reset_overrun", overrun, 0);
      check("reset_state", int'(dut.state_q), int'(IDLE));
      check_bars("reset_bars");
      start_frame();
      finish_frame(cyc);
      check("busy_cycles_zero_frame", cyc, 64);
      check("state_hold", int'(dut.state_q), int'(HOLD));
      vsync_fall();
      check_bars("zero_frame_bars");
      check("no_overrun_yet", ovr_cnt, 0);

      // 2: bin 5 = 6400 - j3200 -> 150, then decays by 2 per frame
      set_bin(5, 6400, -3200);
      start_frame(); finish_frame(cyc); vsync_fall();
      exp_bars[5] = 150;
      check_bars("bin5_150");
      clear_bins();
      start_frame(); finish_frame(cyc); vsync_fall();
      exp_bars[5] = 148;
      check_bars("bin5_148");
      start_frame(); finish_frame(cyc); vsync_fall();
      exp_bars[5] = 146;
      check_bars("bin5_146");

      // 3: saturation, smallest nonzero bar, decay floor at zero
      set_bin(0, -131072, -131072);
      set_bin(1, 127, 0);
      start_frame(); finish_frame(cyc); vsync_fall();
      exp_bars[0] = 480; exp_bars[1] = 1; exp_bars[5] = 144;
      check_bars("saturate_480");
      clear_bins();
      start_frame(); finish_frame(cyc); vsync_fall();
      exp_bars[0] = 478; exp_bars[1] = 0; exp_bars[5] = 142;
      check_bars("decay_floor");

      // 4a: rise mid-CALC is dropped and the snapshot is kept
      set_bin(7, 640, 0);
      start_frame();
      for (int k = 0; k < 10; k++) tick();
      set_bin(7, 6400, 0);
      set_bin(9, 6400, 0);
      fft_done = 1'b1;
      tick();
      check("overrun_calc_pulse", overrun, 1);
      fft_done = 1'b0;
      tick();
      check("overrun_calc_clear", overrun, 0);
      finish_frame(cyc);
      vsync_fall();
      exp_bars[0] = 476; exp_bars[5] = 140; exp_bars[7] = 10;
      check_bars("first_snapshot_only");

      // 4b: rise coincident with the swap edge in HOLD
      clear_bins();
      start_frame(); finish_frame(cyc);
      fft_done = 1'b1;
      vsync = 1'b0;
      tick();
      check("overrun_hold_pulse", overrun, 1);
      check("hold_swap_state", int'(dut.state_q), int'(IDLE));
      exp_bars[0] = 474; exp_bars[5] = 138; exp_bars[7] = 8;
      check_bars("hold_swap_bars");
      fft_done = 1'b0;
      vsync = 1'b1;
      tick();
      check("overrun_hold_clear", overrun, 0);
      check("overrun_total", ovr_cnt, 2);

      // 5: vsync fall during CALC does not swap
      start_frame();
      for (int k = 0; k < 5; k++) tick();
      vsync = 1'b0;
      tick();
      check_bars("no_swap_in_calc");
      vsync = 1'b1;
      tick();
      finish_frame(cyc);
      check_bars("no_swap_before_fall");
      vsync_fall();
      exp_bars[0] = 472; exp_bars[5] = 136; exp_bars[7] = 6;
      check_bars("swap_after_hold");

      // 6: reset mid-CALC, then a clean frame
      start_frame();
      n = 0;
      while (dut.idx_q != 6'd30 && n < 100) begin
         n++;
         tick();
      end
      check("reach_idx30", int'(dut.idx_q), 30);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < POINTS; i++) exp_bars[i] = 0;
      check_bars("reset_mid_calc_bars");
      check("reset_mid_calc_busy", busy, 0);
      check("reset_mid_calc_state", int'(dut.state_q), int'(IDLE));
      tick();
      set_bin(3, 0, 1280);
      start_frame();
      check("restart_idx0", int'(dut.idx_q), 0);
      finish_frame(cyc);
      check("busy_cycles_after_reset", cyc, 64);
      vsync_fall();
      exp_bars[3] = 20;
      check_bars("clean_restart_bars");
      check("overrun_total_final", ovr_cnt, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
